iter_counter: RTL and testbench

- Parametrised successor to the fixed 6-bit T-enabled counter.
- Adds generic width, a programmable terminal value, up/down counting, wrap or saturate mode, and parallel load.
- Adds a start/busy/done run controller, so the multiply/divide unit can sequence its iteration count: 32 cycles for a 32-bit op, or fewer for early-terminating modes.
- Sits beside the multdiv datapath and drives its step enable and result-ready.

---
 rtl/multdiv_pkg.sv | 14 +
 rtl/iter_counter_next.sv | 50 +++++
 rtl/iter_counter.sv | 87 ++++++++
 tb/tb_iter_counter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings for the multiply/divide sequencing logic.
// Holds the iteration-counter FSM state and boundary-mode constants.
package multdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/iter_counter_next.sv
// Next-count and terminal-count logic for the iteration counter; purely combinational.
// No flow control: the result is valid in the same cycle as its inputs.
module iter_counter_next
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MAX   = 63,
  parameter int MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_count_nxt,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic w_at_max;
  logic w_over_max;
  logic w_at_zero;

  assign w_at_max   = (i_count == MAX_W);
  assign w_over_max = (i_count > MAX_W);
  assign w_at_zero  = (i_count == '0);

  assign o_tc = i_en & ((i_up & w_at_max) | (~i_up & w_at_zero));

  // A loaded value above MAX takes the up-boundary path but decrements normally.
  always_comb begin
    o_count_nxt = i_count;
    if (i_en) begin
      if (i_up) begin
        if (w_at_max || w_over_max) begin
          o_count_nxt = (MODE == MODE_SAT) ? MAX_W : '0;
        end else begin
          o_count_nxt = i_count + ONE_W;
        end
      end else begin
        if (w_at_zero) begin
          o_count_nxt = (MODE == MODE_SAT) ? '0 : MAX_W;
        end else begin
          o_count_nxt = i_count - ONE_W;
        end
      end
    end
  end

endmodule

// File: rtl/iter_counter.sv
// Iteration counter with start/busy/done run control; count, busy, done are registered, tc is combinational.
// No backpressure: start is ignored while running, load and en always act on the next edge.
module iter_counter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MAX   = 63,
  parameter int MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  if ((MAX < 1) || (longint'(MAX) >= (longint'(1) << WIDTH))) begin : g_bad_max
    $error("iter_counter: MAX must satisfy 1 <= MAX <= 2**WIDTH-1");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_step;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc;
  logic             w_start_acc;
  logic             r_busy;
  logic             r_done;

  iter_counter_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX),
    .MODE  (MODE)
  ) u_next (
    .i_count     (r_count),
    .i_en        (en),
    .i_up        (up),
    .o_count_nxt (w_count_step),
    .o_tc        (w_tc)
  );

  assign w_start_acc = start & (r_state != S_RUN);

  // Load owns the count but never blocks a start; in RUN it defers completion.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = w_count_step;
    if (load) begin
      w_count_nxt = load_val;
    end else if (w_start_acc) begin
      w_count_nxt = '0;
    end
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_tc && !load) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign count = r_count;
  assign tc    = w_tc;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_iter_counter.sv
// Bench for iter_counter: directed scenarios on four parameterisations plus a randomized run
// checked against an arithmetic reference model.
module tb_iter_counter;

  logic       clk = 1'b0;
  logic       clr_n, en, up, load, start;
  logic [5:0] load_val;
  logic [5:0] cnt_a, cnt_b, cnt_d;
  logic [4:0] cnt_c;
  logic [3:0] tc_v, busy_v, done_v;
  int         obs_cnt [4];
  int         total = 0;
  int         bad = 0;

  // instance 0: wrap 63, 1: sat 63, 2: 5-bit wrap 31, 3: sat with MAX=40
  localparam int P_MAX  [4] = '{63, 63, 31, 40};
  localparam bit P_SAT  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam int P_MASK [4] = '{63, 63, 31, 63};

  int m_cnt  [4];
  bit m_busy [4];
  bit m_done [4];

  always #5 clk = ~clk;

  iter_counter #(.WIDTH(6), .MAX(63), .MODE(0)) u_wrap (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .start(start), .count(cnt_a), .tc(tc_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  iter_counter #(.WIDTH(6), .MAX(63), .MODE(1)) u_sat (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .start(start), .count(cnt_b), .tc(tc_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  iter_counter #(.WIDTH(5), .MAX(31), .MODE(0)) u_w5 (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load), .load_val(load_val[4:0]),
    .start(start), .count(cnt_c), .tc(tc_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  iter_counter #(.WIDTH(6), .MAX(40), .MODE(1)) u_m40 (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .start(start), .count(cnt_d), .tc(tc_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  always_comb begin
    obs_cnt[0] = int'(cnt_a);
    obs_cnt[1] = int'(cnt_b);
    obs_cnt[2] = int'(cnt_c);
    obs_cnt[3] = int'(cnt_d);
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
  endfunction

  function automatic bit model_tc(int i);
    return en && ((up && m_cnt[i] == P_MAX[i]) || (!up && m_cnt[i] == 0));
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 4; i++) begin
      bit hit;
      bit take;
      int nxt;
      hit  = model_tc(i);
      take = start && !m_busy[i];
      if (load)       nxt = int'(load_val) & P_MASK[i];
      else if (take)  nxt = 0;
      else if (!en)   nxt = m_cnt[i];
      else if (up)    nxt = (m_cnt[i] >= P_MAX[i]) ? (P_SAT[i] ? P_MAX[i] : 0) : m_cnt[i] + 1;
      else            nxt = (m_cnt[i] == 0) ? (P_SAT[i] ? 0 : P_MAX[i]) : m_cnt[i] - 1;
      m_done[i] = m_busy[i] && hit && !load;
      m_busy[i] = take || (m_busy[i] && !(hit && !load));
      m_cnt[i]  = nxt;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!clr_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; up = 1'b0; load = 1'b0; start = 1'b0; load_val = '0;
    clr_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_cnt[i] !== 0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state[%0d] got cnt=%0d busy=%b done=%b want 0/0/0", i, obs_cnt[i], busy_v[i], done_v[i]);
      end
    end
    start = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (cnt_a !== 6'd2 || busy_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL pre_abort got cnt=%0d busy=%b want 2/1", cnt_a, busy_v[0]);
    end
    #3;
    clr_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (cnt_a !== 6'd0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_clear got cnt=%0d busy=%b done=%b want 0/0/0", cnt_a, busy_v[0], done_v[0]);
    end
    clr_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (cnt_a !== 6'(k) || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
        bad++;
        $display("FAIL post_release_%0d got cnt=%0d busy=%b done=%b want %0d/0/0", k, cnt_a, busy_v[0], done_v[0], k);
      end
    end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    load = 1'b1; load_val = 6'd62;
    tick();
    total++;
    if (cnt_a !== 6'd62 || cnt_b !== 6'd62) begin
      bad++;
      $display("FAIL ws_load got a=%0d b=%0d want 62", cnt_a, cnt_b);
    end
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    total++;
    if (tc_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL ws_tc_62 got %b want 0", tc_v[0]);
    end
    tick();
    total++;
    if (cnt_a !== 6'd63 || tc_v[0] !== 1'b1 || cnt_b !== 6'd63 || tc_v[1] !== 1'b1) begin
      bad++;
      $display("FAIL ws_at_max got a=%0d/%b b=%0d/%b want 63/1 63/1", cnt_a, tc_v[0], cnt_b, tc_v[1]);
    end
    total++;
    if (cnt_d !== 6'd40) begin
      bad++;
      $display("FAIL above_max_clamp got %0d want 40", cnt_d);
    end
    tick();
    total++;
    if (cnt_a !== 6'd0 || tc_v[0] !== 1'b0 || cnt_b !== 6'd63 || tc_v[1] !== 1'b1) begin
      bad++;
      $display("FAIL ws_boundary got a=%0d/%b b=%0d/%b want 0/0 63/1", cnt_a, tc_v[0], cnt_b, tc_v[1]);
    end
    tick();
    total++;
    if (cnt_a !== 6'd1 || cnt_b !== 6'd63 || tc_v[1] !== 1'b1) begin
      bad++;
      $display("FAIL ws_hold got a=%0d b=%0d/%b want 1 63/1", cnt_a, cnt_b, tc_v[1]);
    end
    load = 1'b1; load_val = 6'd1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    total++;
    if (cnt_a !== 6'd0 || cnt_b !== 6'd0 || tc_v[0] !== 1'b1 || tc_v[1] !== 1'b1) begin
      bad++;
      $display("FAIL down_zero got a=%0d/%b b=%0d/%b want 0/1 0/1", cnt_a, tc_v[0], cnt_b, tc_v[1]);
    end
    tick();
    total++;
    if (cnt_a !== 6'd63 || cnt_b !== 6'd0) begin
      bad++;
      $display("FAIL down_boundary got a=%0d b=%0d want 63 0", cnt_a, cnt_b);
    end
  endtask

  task automatic test_run_handshake();
    int bc;
    do_reset();
    start = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    start = 1'b0;
    bc = busy_v[0] ? 1 : 0;
    total++;
    if (cnt_a !== 6'd0 || busy_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL run_start got cnt=%0d busy=%b want 0/1", cnt_a, busy_v[0]);
    end
    for (int k = 1; k <= 63; k++) begin
      start = (k == 11);
      tick();
      start = 1'b0;
      if (busy_v[0]) bc++;
      total++;
      if (cnt_a !== 6'(k) || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        bad++;
        $display("FAIL run_step_%0d got cnt=%0d busy=%b done=%b want %0d/1/0", k, cnt_a, busy_v[0], done_v[0], k);
      end
    end
    tick();
    if (busy_v[0]) bc++;
    total++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || cnt_a !== 6'd0) begin
      bad++;
      $display("FAIL run_done got done=%b busy=%b cnt=%0d want 1/0/0", done_v[0], busy_v[0], cnt_a);
    end
    tick();
    total++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL run_idle got done=%b busy=%b want 0/0", done_v[0], busy_v[0]);
    end
    total++;
    if (bc !== 64) begin
      bad++;
      $display("FAIL busy_cycles got %0d want 64", bc);
    end
  endtask

  task automatic test_start_in_done();
    do_reset();
    load = 1'b1; load_val = 6'd62; start = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick();
    tick();
    total++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || cnt_a !== 6'd0) begin
      bad++;
      $display("FAIL sid_done got done=%b busy=%b cnt=%0d want 1/0/0", done_v[0], busy_v[0], cnt_a);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (cnt_a !== 6'd0 || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL sid_restart got cnt=%0d busy=%b done=%b want 0/1/0", cnt_a, busy_v[0], done_v[0]);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    load = 1'b1; load_val = 6'd5; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    total++;
    if (cnt_a !== 6'd5 || busy_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL load_start got cnt=%0d busy=%b want 5/1", cnt_a, busy_v[0]);
    end
    en = 1'b1; up = 1'b1;
    tick();
    en = 1'b0; load = 1'b1; load_val = 6'd40;
    tick();
    load = 1'b0;
    total++;
    if (cnt_a !== 6'd40 || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL load_mid_run got cnt=%0d busy=%b done=%b want 40/1/0", cnt_a, busy_v[0], done_v[0]);
    end
    tick();
    total++;
    if (cnt_a !== 6'd40 || busy_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL en_low_hold got cnt=%0d busy=%b want 40/1", cnt_a, busy_v[0]);
    end
  endtask

  task automatic test_param_w5();
    int exp_a [4];
    int exp_b [8];
    exp_a = '{2, 1, 0, 31};
    exp_b = '{3, 2, 2, 1, 1, 0, 0, 31};
    do_reset();
    load = 1'b1; load_val = 6'd3; start = 1'b1; up = 1'b0; en = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    total++;
    if (cnt_c !== 5'd3 || busy_v[2] !== 1'b1) begin
      bad++;
      $display("FAIL w5_start got cnt=%0d busy=%b want 3/1", cnt_c, busy_v[2]);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      total++;
      if (int'(cnt_c) !== exp_a[j] || done_v[2] !== (j == 3) || busy_v[2] !== (j != 3)) begin
        bad++;
        $display("FAIL w5_down_%0d got cnt=%0d done=%b busy=%b want %0d", j, cnt_c, done_v[2], busy_v[2], exp_a[j]);
      end
    end
    do_reset();
    load = 1'b1; load_val = 6'd3; start = 1'b1; up = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      en = ((j % 2) == 1);
      tick();
      total++;
      if (int'(cnt_c) !== exp_b[j] || done_v[2] !== (j == 7) || busy_v[2] !== (j != 7)) begin
        bad++;
        $display("FAIL w5_toggle_%0d got cnt=%0d done=%b busy=%b want %0d", j, cnt_c, done_v[2], busy_v[2], exp_b[j]);
      end
    end
    en = 1'b0;
    tick();
    total++;
    if (done_v[2] !== 1'b0 || busy_v[2] !== 1'b0) begin
      bad++;
      $display("FAIL w5_one_shot got done=%b busy=%b want 0/0", done_v[2], busy_v[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      clr_n = ($urandom_range(0, 299) != 0);
      if (!clr_n) model_reset();
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 15) == 0);
      start    = ($urandom_range(0, 7) == 0);
      load_val = 6'($urandom_range(0, 63));
      #1;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (tc_v[i] !== model_tc(i)) begin
          bad++;
          $display("FAIL rand_tc[%0d] n=%0d got=%b want=%b", i, n, tc_v[i], model_tc(i));
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_cnt[i] !== m_cnt[i] || busy_v[i] !== m_busy[i] || done_v[i] !== m_done[i]) begin
          bad++;
          $display("FAIL rand_state[%0d] n=%0d got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                   i, n, obs_cnt[i], busy_v[i], done_v[i], m_cnt[i], m_busy[i], m_done[i]);
        end
      end
    end
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; start = 1'b0; load_val = '0;
    model_reset();
    test_reset();
    test_wrap_sat();
    test_run_handshake();
    test_start_in_done();
    test_load_priority();
    test_param_w5();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
